// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch control slice: FSM state encodings,
// packing of the eight BCD digits in a 32-bit word, and blink timing defaults.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_RUNNING = 2'b01,
        S_SPLIT   = 2'b10,
        S_STOP    = 2'b11
    } sw_state_t;

    localparam int DIGIT_W    = 4;
    localparam int NUM_DIGITS = 8;
    localparam int DIGITS_W   = DIGIT_W * NUM_DIGITS;

    // Digits are packed MSB-first: hours in the top byte, centiseconds at the bottom.
    localparam int HR_1_LSB   = 28;
    localparam int HR_0_LSB   = 24;
    localparam int MIN_1_LSB  = 20;
    localparam int MIN_0_LSB  = 16;
    localparam int SEC_1_LSB  = 12;
    localparam int SEC_0_LSB  = 8;
    localparam int CENT_1_LSB = 4;
    localparam int CENT_0_LSB = 0;

    localparam int BLINK_TICKS_DEFAULT = 500;
    localparam int BLINK_CNT_W_DEFAULT = 9;

endpackage

// File: rtl/stopwatch_if.sv
// Bundle of pulse inputs, counter handshake and display outputs around the
// stopwatch control FSM.
interface stopwatch_if;
    import stopwatch_pkg::*;

    logic                start_ed;
    logic                stop_ed;
    logic                split_ed;
    logic                tick_ms;
    logic [DIGITS_W-1:0] cnt_digits;
    logic                cnt_tick;
    logic                cnt_clr;
    logic [DIGITS_W-1:0] disp_digits;
    logic                disp_blank;
    logic [1:0]          state;

    modport master (
        output start_ed, stop_ed, split_ed, tick_ms, cnt_digits,
        input  cnt_tick, cnt_clr, disp_digits, disp_blank, state
    );

    modport slave (
        input  start_ed, stop_ed, split_ed, tick_ms, cnt_digits,
        output cnt_tick, cnt_clr, disp_digits, disp_blank, state
    );

endinterface

// File: rtl/stopwatch_blink.sv
// Display blink timer: counts ms ticks while enabled and toggles the blank
// flag every BLINK_TICKS ticks; fully cleared whenever disabled.
module blink_timer #(
    parameter int BLINK_TICKS = 500,
    parameter int CNT_W       = 9
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic tick,
    output logic blank
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(BLINK_TICKS - 1);

    logic [CNT_W-1:0] count;
    logic             blank_q;

    // Holding the counter at zero while disabled gives a fresh phase on every entry.
    always_ff @(posedge clk) begin
        if (!rst || !en) begin
            count   <= '0;
            blank_q <= 1'b0;
        end else if (tick) begin
            if (count == LAST) begin
                count   <= '0;
                blank_q <= ~blank_q;
            end else begin
                count <= count + CNT_W'(1);
            end
        end
    end

    // Masking with en keeps a toggle taken on the exit edge from leaking out.
    assign blank = blank_q & en;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencing FSM: gates and clears the BCD counters, owns the split
// snapshot / display register and drives the blink timer while stopped.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int BLINK_TICKS = BLINK_TICKS_DEFAULT,
    parameter int CNT_W       = BLINK_CNT_W_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    stopwatch_if.slave bus
);

    sw_state_t           state_q;
    sw_state_t           state_d;
    logic [DIGITS_W-1:0] disp_q;
    logic                blank;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Pulse priority is stop > split > start; lower-priority pulses are dropped.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (!bus.stop_ed && !bus.split_ed && bus.start_ed) begin
                    state_d = S_RUNNING;
                end
            end
            S_RUNNING: begin
                if (bus.stop_ed) begin
                    state_d = S_STOP;
                end else if (bus.split_ed) begin
                    state_d = S_SPLIT;
                end
            end
            S_SPLIT: begin
                if (bus.stop_ed) begin
                    state_d = S_STOP;
                end else if (bus.split_ed) begin
                    state_d = S_RUNNING;
                end
            end
            S_STOP: begin
                if (bus.stop_ed) begin
                    state_d = S_IDLE;
                end else if (!bus.split_ed && bus.start_ed) begin
                    state_d = S_RUNNING;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // The load on the RUNNING->SPLIT edge is the snapshot; SPLIT then freezes it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            disp_q <= '0;
        end else if (state_q != S_SPLIT) begin
            disp_q <= bus.cnt_digits;
        end
    end

    blink_timer #(
        .BLINK_TICKS (BLINK_TICKS),
        .CNT_W       (CNT_W)
    ) u_blink (
        .clk   (clk),
        .rst   (rst),
        .en    (state_q == S_STOP),
        .tick  (bus.tick_ms),
        .blank (blank)
    );

    assign bus.cnt_tick    = bus.tick_ms && ((state_q == S_RUNNING) || (state_q == S_SPLIT));
    assign bus.cnt_clr     = (state_q == S_IDLE);
    assign bus.disp_digits = disp_q;
    assign bus.disp_blank  = blank;
    assign bus.state       = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: a directed vector table, hand-written
// corner sequences and randomized pulses against a behavioural stopwatch model.
module tb_stopwatch_ctrl;

    localparam int BLINK = 4;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    stopwatch_if bus ();

    stopwatch_ctrl #(
        .BLINK_TICKS (BLINK),
        .CNT_W       (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Behavioural model: "counting" covers running and split, "frozen" means
    // the display is held, "paused" means stopped with blinking.
    bit          m_valid = 1'b0;
    bit          m_counting = 1'b0;
    bit          m_frozen = 1'b0;
    bit          m_paused = 1'b0;
    int          m_stop_ticks = 0;
    logic [31:0] m_disp = '0;

    typedef struct {
        logic        rst;
        logic        start;
        logic        stop;
        logic        split;
        logic        tick;
        logic [31:0] digits;
        logic [1:0]  e_state;
        logic        e_tick;
        logic        e_clr;
        logic        e_blank;
        logic [31:0] e_disp;
    } vec_t;

    vec_t table_v[$];

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_inputs(input logic r, input logic st, input logic sp,
                                input logic spl, input logic t, input logic [31:0] d);
        rst            = r;
        bus.start_ed   = st;
        bus.stop_ed    = sp;
        bus.split_ed   = spl;
        bus.tick_ms    = t;
        bus.cnt_digits = d;
    endtask

    // Compares all outputs against the model before the next edge.
    task automatic check_output();
        logic [1:0] e_state;
        if (!m_valid) return;
        e_state = m_paused ? 2'b11 : (m_frozen ? 2'b10 : (m_counting ? 2'b01 : 2'b00));
        check_val("model_state", 32'(bus.state), 32'(e_state));
        check_val("model_cnt_tick", 32'(bus.cnt_tick), 32'(bus.tick_ms && m_counting));
        check_val("model_cnt_clr", 32'(bus.cnt_clr), 32'(!m_counting && !m_paused));
        check_val("model_disp", bus.disp_digits, m_disp);
        check_val("model_blank", 32'(bus.disp_blank),
                  32'(m_paused && (((m_stop_ticks / BLINK) % 2) == 1)));
    endtask

    task automatic model_edge();
        if (!rst) begin
            m_counting   = 1'b0;
            m_frozen     = 1'b0;
            m_paused     = 1'b0;
            m_stop_ticks = 0;
            m_disp       = '0;
        end else begin
            if (!m_frozen) m_disp = bus.cnt_digits;
            if (m_paused && bus.tick_ms) m_stop_ticks++;
            if (bus.stop_ed) begin
                if (m_counting) begin
                    m_counting   = 1'b0;
                    m_frozen     = 1'b0;
                    m_paused     = 1'b1;
                    m_stop_ticks = 0;
                end else if (m_paused) begin
                    m_paused     = 1'b0;
                    m_stop_ticks = 0;
                end
            end else if (bus.split_ed) begin
                if (m_counting) m_frozen = !m_frozen;
            end else if (bus.start_ed) begin
                if (!m_counting) begin
                    m_counting   = 1'b1;
                    m_paused     = 1'b0;
                    m_stop_ticks = 0;
                end
            end
        end
        m_valid = 1'b1;
    endtask

    task automatic advance_clock();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic apply_stimulus(input logic r, input logic st, input logic sp,
                                  input logic spl, input logic t, input logic [31:0] d);
        drive_inputs(r, st, sp, spl, t, d);
        #1;
        check_output();
        advance_clock();
    endtask

    task automatic add_vec(input logic r, input logic st, input logic sp, input logic spl,
                           input logic t, input logic [31:0] d, input logic [1:0] es,
                           input logic et, input logic ec, input logic eb, input logic [31:0] ed);
        vec_t v;
        v.rst = r; v.start = st; v.stop = sp; v.split = spl; v.tick = t; v.digits = d;
        v.e_state = es; v.e_tick = et; v.e_clr = ec; v.e_blank = eb; v.e_disp = ed;
        table_v.push_back(v);
    endtask

    initial begin
        drive_inputs(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

        // Expected outputs are those seen in the cycle the row's inputs are applied.
        add_vec(1, 0, 0, 0, 1, 32'h11, 2'b00, 0, 1, 0, 32'h00);
        add_vec(1, 1, 0, 0, 0, 32'h22, 2'b00, 0, 1, 0, 32'h11);
        add_vec(1, 0, 0, 0, 1, 32'h33, 2'b01, 1, 0, 0, 32'h22);
        add_vec(1, 0, 1, 0, 1, 32'h44, 2'b01, 1, 0, 0, 32'h33);
        add_vec(1, 0, 0, 0, 1, 32'h44, 2'b11, 0, 0, 0, 32'h44);
        add_vec(1, 0, 0, 0, 1, 32'h44, 2'b11, 0, 0, 0, 32'h44);
        add_vec(1, 0, 0, 0, 1, 32'h44, 2'b11, 0, 0, 0, 32'h44);
        add_vec(1, 0, 0, 0, 1, 32'h44, 2'b11, 0, 0, 0, 32'h44);
        add_vec(1, 0, 0, 0, 0, 32'h44, 2'b11, 0, 0, 1, 32'h44);
        add_vec(1, 0, 1, 0, 1, 32'h55, 2'b11, 0, 0, 1, 32'h44);
        add_vec(1, 0, 0, 0, 1, 32'h66, 2'b00, 0, 1, 0, 32'h55);

        // Reset held low for three edges, with ticks that must not pass.
        for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h9999);
        check_val("reset_state", 32'(bus.state), 32'h0);
        check_val("reset_clr", 32'(bus.cnt_clr), 32'h1);
        check_val("reset_tick", 32'(bus.cnt_tick), 32'h0);
        check_val("reset_disp", bus.disp_digits, 32'h0);

        foreach (table_v[i]) begin
            drive_inputs(table_v[i].rst, table_v[i].start, table_v[i].stop,
                         table_v[i].split, table_v[i].tick, table_v[i].digits);
            #1;
            check_output();
            check_val($sformatf("vec%0d_state", i), 32'(bus.state), 32'(table_v[i].e_state));
            check_val($sformatf("vec%0d_tick", i), 32'(bus.cnt_tick), 32'(table_v[i].e_tick));
            check_val($sformatf("vec%0d_clr", i), 32'(bus.cnt_clr), 32'(table_v[i].e_clr));
            check_val($sformatf("vec%0d_blank", i), 32'(bus.disp_blank), 32'(table_v[i].e_blank));
            check_val($sformatf("vec%0d_disp", i), bus.disp_digits, table_v[i].e_disp);
            advance_clock();
        end

        // Split snapshot while the counters ramp underneath.
        apply_stimulus(1, 1, 0, 0, 0, 32'h1200);
        apply_stimulus(1, 0, 0, 1, 1, 32'h1234);
        for (int k = 35; k <= 99; k++) begin
            apply_stimulus(1, 0, 0, 0, 1, 32'h1200 | 32'((k / 10) << 4) | 32'(k % 10));
            check_val("split_tick_live", 32'(bus.cnt_tick), 32'h1);
        end
        check_val("split_hold", bus.disp_digits, 32'h1234);
        check_val("split_state", 32'(bus.state), 32'h2);
        apply_stimulus(1, 0, 0, 1, 0, 32'h1299);
        check_val("unsplit_first", bus.disp_digits, 32'h1234);
        apply_stimulus(1, 0, 0, 0, 0, 32'h1300);
        check_val("unsplit_live", bus.disp_digits, 32'h1300);

        // All three pulses at once while running: stop wins, no snapshot.
        apply_stimulus(1, 1, 1, 1, 0, 32'h5555);
        check_val("simul_state", 32'(bus.state), 32'h3);
        check_val("simul_disp", bus.disp_digits, 32'h5555);

        // Blink in STOP, then clear back to idle.
        for (int i = 0; i < 12; i++) begin
            apply_stimulus(1, 0, 0, 0, 1, 32'h5555);
            check_val($sformatf("blink_t%0d", i + 1), 32'(bus.disp_blank),
                      32'((((i + 1) / BLINK) % 2) == 1));
        end
        apply_stimulus(1, 0, 1, 0, 0, 32'h5555);
        check_val("clear_state", 32'(bus.state), 32'h0);
        check_val("clear_clr", 32'(bus.cnt_clr), 32'h1);
        check_val("clear_blank", 32'(bus.disp_blank), 32'h0);

        // Reset in the middle of a split.
        apply_stimulus(1, 1, 0, 0, 0, 32'h0);
        apply_stimulus(1, 0, 0, 1, 0, 32'hABCD);
        apply_stimulus(1, 0, 0, 0, 1, 32'hABCE);
        apply_stimulus(0, 0, 0, 0, 1, 32'hABCF);
        check_val("rst_split_state", 32'(bus.state), 32'h0);
        check_val("rst_split_disp", bus.disp_digits, 32'h0);
        check_val("rst_split_tick", 32'(bus.cnt_tick), 32'h0);

        // Randomized pulses and ticks against the model.
        for (int i = 0; i < 4000; i++) begin
            apply_stimulus(logic'($urandom_range(0, 199) != 0),
                           logic'($urandom_range(0, 5) == 0),
                           logic'($urandom_range(0, 11) == 0),
                           logic'($urandom_range(0, 7) == 0),
                           logic'($urandom_range(0, 2) == 0),
                           32'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
